fpu_divider: RTL and testbench
==============================

// Module: fpu_divider
// PURPOSE
//  Multi-cycle 32-bit integer divider on the FP register-file operand buses (fbusA/fbusB); the inverse of the FPU multiply path.
//  Radix-2 restoring division, one quotient bit per clock.
//  Supports signed (DIV) and unsigned (DIVU) modes; the multi-cycle controller starts it and stalls on busy.
//  Quotient and remainder stay held for the FPU writeback mux until the next start.
// PARAMETERS
//  WIDTH      32   operand/result width; iteration count = WIDTH
//  CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  div_signed in   1      1 = signed DIV, 0 = unsigned DIVU; sampled with start
//  fbusA      in   [0:31] dividend (bit 31 = LSB)
//  fbusB      in   [0:31] divisor (bit 31 = LSB)
//  busy       out  1      high from the cycle after start is accepted until done
//  done       out  1      one-cycle pulse; results valid from this cycle on
//  quotient   out  [0:31] result, held until next accepted start
//  remainder  out  [0:31] result, held until next accepted start
//  div_zero   out  1      divisor was zero; held with the results
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; busy, done, div_zero=0; quotient, remainder=0; counter=0.
//  FSM: IDLE -> LOAD -> CALC (WIDTH cycles) -> FIX -> IDLE.
//   IDLE: if start=1, latch operands and div_signed -> LOAD. start=0 holds IDLE with outputs unchanged.
//   LOAD: form magnitudes (negate an operand if signed and its MSB, bit 0, =1); record qneg = sA^sB and rneg = sA.
//         Divisor==0 -> skip to FIX with dz set.
//   CALC: per cycle, shift {rem,dvd} left 1; trial = rem - divisor; if no borrow, rem = trial and qbit = 1.
//         counter counts 0..WIDTH-1; exits to FIX after the WIDTH-th iteration.
//   FIX: quotient = qneg ? -q : q; remainder = rneg ? -r : r (signed mode only); done=1 for this cycle; -> IDLE.
//  Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH+2 (34 for WIDTH=32).
//           Divide-by-zero: done after edge 2.
//  busy=1 in LOAD, CALC and FIX; done=1 only in FIX.
//  start while busy: ignored, no queuing, no effect on the current operation.
//  Divide by zero: quotient = all ones, remainder = dividend unmodified, div_zero=1. No sign fix in either mode.
//  Signed semantics: truncate toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
//  Overflow 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0, no flag.
//   Falls out of the WIDTH-bit magnitude math.
//  Magnitude of 0x80000000 is 2^31, carried unsigned in WIDTH bits; the remainder register is WIDTH+1 bits for the borrow.
//  Results and div_zero change only in FIX, or at reset. div_zero is cleared in LOAD of the next op.
//  Reset asserted mid-operation: aborts immediately; all outputs take reset values; no done pulse.
// CONFIGURATION
//  FPU_DIV_REM_EN defined: remainder port is driven as specified above.
//  FPU_DIV_REM_EN undefined:
//   - remainder is tied to 0 and the sign fix for it is removed;
//   - quotient, done and div_zero behaviour and latency are unchanged.
// TESTING
//  1. Unsigned 100/7 (fbusA=0x64, fbusB=0x7, div_signed=0).
//     -> quotient=0x0000000E, remainder=0x00000002, div_zero=0; done exactly 34 cycles after start.
//  2. Signed -7/2 (0xFFFFFFF9 / 0x00000002).
//     -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Same operands unsigned: quotient=0x7FFFFFFC, remainder=0x1.
//  3. 5/0, either mode.
//     -> done 2 cycles after start; quotient=0xFFFFFFFF, remainder=0x5, div_zero=1; next valid op clears div_zero.
//  4. 0x80000000/0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
//     Unsigned -> quotient=0, remainder=0x80000000.
//  5. Pulse start with 9/3 at cycle 10 of a running 100/7.
//     -> ignored; first op's results and done timing are unchanged; no second done.
//  6. Drop reset_n low mid-CALC.
//     -> busy, done, quotient, remainder, div_zero = 0 at once; after release, 1/1 gives quotient=1, remainder=0.

Source files
------------

// File: rtl/fpu_divider.sv
// fpu_divider: multi-cycle 32-bit integer divider fed from the FP register-file
// operand buses. Radix-2 restoring division, one quotient bit per clock, signed
// (DIV) and unsigned (DIVU) modes. Results and div_zero stay held for the FPU
// writeback mux until the next accepted start.
//
// Configuration macro: FPU_DIV_REM_EN
//   defined   -> remainder port carries the signed/unsigned remainder
//   undefined -> remainder port is tied to zero; quotient, done, div_zero and
//                latency are identical in both builds
//
// Bus bit order: fbusA/fbusB/quotient/remainder are declared [0:WIDTH-1], so
// bit 0 is the MSB and bit WIDTH-1 the LSB. Internally everything is kept in
// [WIDTH-1:0] form; plain assignment between the two preserves numeric value.

module fpu_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             div_signed,
    input  logic [0:WIDTH-1] fbusA,
    input  logic [0:WIDTH-1] fbusB,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] quotient,
    output logic [0:WIDTH-1] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic             signed_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qneg_q;
    logic             zeroDiv_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic [WIDTH-1:0] quot_q;
`ifdef FPU_DIV_REM_EN
    logic             rneg_q;
    logic [WIDTH-1:0] remOut_q;
`endif

    logic             signA_d;
    logic             signB_d;
    logic [WIDTH-1:0] magA_d;
    logic [WIDTH-1:0] magB_d;
    logic [WIDTH:0]   remShift_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic             qbit_d;

    // Operand magnitudes for LOAD and one restoring step for CALC. The trial
    // difference is WIDTH+1 bits so its top bit is the borrow; a magnitude of
    // 2^(WIDTH-1) (most negative dividend/divisor) still fits unsigned.
    always_comb begin
        signA_d    = signed_q & opA_q[WIDTH-1];
        signB_d    = signed_q & opB_q[WIDTH-1];
        magA_d     = signA_d ? -opA_q : opA_q;
        magB_d     = signB_d ? -opB_q : opB_q;
        remShift_d = {rem_q, dvd_q[WIDTH-1]};
        trial_d    = remShift_d - {1'b0, dsr_q};
        qbit_d     = ~trial_d[WIDTH];
        rem_d      = qbit_d ? trial_d[WIDTH-1:0] : remShift_d[WIDTH-1:0];
        dvd_d      = {dvd_q[WIDTH-2:0], qbit_d};
    end

    // Divider controller and datapath: IDLE -> LOAD -> CALC x WIDTH -> FIX.
    // All outputs are registered; done pulses on the edge that leaves FIX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            signed_q  <= 1'b0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            zeroDiv_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            quot_q    <= '0;
`ifdef FPU_DIV_REM_EN
            rneg_q    <= 1'b0;
            remOut_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q    <= fbusA;
                        opB_q    <= fbusB;
                        signed_q <= div_signed;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    dvd_q     <= magA_d;
                    dsr_q     <= magB_d;
                    rem_q     <= '0;
                    cnt_q     <= '0;
                    qneg_q    <= signA_d ^ signB_d;
`ifdef FPU_DIV_REM_EN
                    rneg_q    <= signA_d;
`endif
                    zeroDiv_q <= (opB_q == '0);
                    dz_q      <= 1'b0;
                    state_q   <= (opB_q == '0) ? FIX : CALC;
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (zeroDiv_q) begin
                        quot_q   <= '1;
`ifdef FPU_DIV_REM_EN
                        remOut_q <= opA_q;
`endif
                    end else begin
                        quot_q   <= qneg_q ? -dvd_q : dvd_q;
`ifdef FPU_DIV_REM_EN
                        remOut_q <= rneg_q ? -rem_q : rem_q;
`endif
                    end
                    dz_q    <= zeroDiv_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign quotient = quot_q;
`ifdef FPU_DIV_REM_EN
    assign remainder = remOut_q;
`else
    assign remainder = '0;
`endif

endmodule

// File: tb/tb_fpu_divider.sv
// tb_fpu_divider: self-checking bench for fpu_divider. A plain-arithmetic
// reference model (64-bit signed/unsigned / and %) supplies every expected
// quotient, remainder, div_zero and latency; directed vectors plus
// randomized operands are run through it.

module tb_fpu_divider;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        div_signed;
    logic [0:31] fbusA;
    logic [0:31] fbusB;
    logic        busy;
    logic        done;
    logic [0:31] quotient;
    logic [0:31] remainder;
    logic        div_zero;

    int nCompared;
    int nMismatched;

    fpu_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .div_signed (div_signed),
        .fbusA      (fbusA),
        .fbusB      (fbusB),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: truncating division in 64-bit arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
        longint sa, sb, lq, lr;
        logic [63:0] uq, ur;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dz  = 1'b1;
            lat = 2;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            lq  = sa / sb;
            lr  = sa % sb;
            uq  = lq;
            ur  = lr;
            q   = uq[31:0];
            r   = ur[31:0];
            dz  = 1'b0;
            lat = 34;
        end
`ifndef FPU_DIV_REM_EN
        r = 32'd0;
`endif
    endfunction

    // Issue one operation and wait (bounded) for done; lat = -1 on timeout
    task automatic doDivide(input logic [31:0] a, input logic [31:0] b, input logic s,
                            output logic [31:0] q, output logic [31:0] r,
                            output logic dz, output int lat);
        @(negedge clk);
        fbusA      = a;
        fbusB      = b;
        div_signed = s;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
    endtask

    // Run an operation and compare every result against the model
    task automatic runAndCheck(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s);
        logic [31:0] q, r, eq, er;
        logic dz, edz;
        int lat, elat;
        model(a, b, s, eq, er, edz, elat);
        doDivide(a, b, s, q, r, dz, lat);
        nCompared++;
        if (q !== eq) begin
            nMismatched++;
            $display("[TB] FAIL %s quotient a=%h b=%h s=%0b: got %h expected %h", name, a, b, s, q, eq);
        end
        nCompared++;
        if (r !== er) begin
            nMismatched++;
            $display("[TB] FAIL %s remainder a=%h b=%h s=%0b: got %h expected %h", name, a, b, s, r, er);
        end
        nCompared++;
        if (dz !== edz) begin
            nMismatched++;
            $display("[TB] FAIL %s div_zero a=%h b=%h: got %0b expected %0b", name, a, b, dz, edz);
        end
        nCompared++;
        if (lat != elat) begin
            nMismatched++;
            $display("[TB] FAIL %s latency a=%h b=%h: got %0d expected %0d", name, a, b, lat, elat);
        end
    endtask

    // Outputs during asynchronous reset
    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        nCompared++;
        if ({busy, done, div_zero} !== 3'b000) begin
            nMismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        end
        nCompared++;
        if ({quotient, remainder} !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_results: got %h expected 0", {quotient, remainder});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Directed vectors: basic, signed, overflow, most-negative cases
    task automatic test_directed();
        runAndCheck("u100div7",   32'h0000_0064, 32'h0000_0007, 1'b0);
        runAndCheck("s-7div2",    32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        runAndCheck("u-7div2",    32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        runAndCheck("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runAndCheck("u_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runAndCheck("s7div-2",    32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
        runAndCheck("s_mindivmin",32'h8000_0000, 32'h8000_0000, 1'b1);
    endtask

    // Divide by zero in both modes, hold of results, clearing of div_zero
    task automatic test_div_zero();
        runAndCheck("s5div0", 32'h0000_0005, 32'h0000_0000, 1'b1);
        runAndCheck("u5div0", 32'h0000_0005, 32'h0000_0000, 1'b0);
        // results held while idle even if the buses change
        @(negedge clk);
        fbusA = 32'h1234_5678;
        fbusB = 32'h0000_0009;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if (quotient !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL dz_hold: got q=%h dz=%0b expected q=ffffffff dz=1", quotient, div_zero);
        end
        // next op: div_zero still set after accept, cleared after LOAD
        @(negedge clk);
        fbusA = 32'd9; fbusB = 32'd3; div_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nCompared++;
        if (div_zero !== 1'b1 || busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL dz_after_accept: got dz=%0b busy=%0b expected dz=1 busy=1", div_zero, busy);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (div_zero !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL dz_cleared_in_load: got %0b expected 0", div_zero);
        end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        nCompared++;
        if (quotient !== 32'd3) begin
            nMismatched++;
            $display("[TB] FAIL dz_next_op_quotient: got %h expected 00000003", quotient);
        end
    endtask

    // Start pulsed mid-operation must be ignored
    task automatic test_start_while_busy();
        int cyc, nDone, firstDone;
        logic [31:0] eq, er;
        logic edz;
        int elat;
        model(32'd100, 32'd7, 1'b0, eq, er, edz, elat);
        @(negedge clk);
        fbusA = 32'd100; fbusB = 32'd7; div_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nDone = 0;
        firstDone = -1;
        for (cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 9) begin
                fbusA = 32'd9; fbusB = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                nDone++;
                if (firstDone < 0) begin
                    firstDone = cyc;
                    nCompared++;
                    if (quotient !== eq || remainder !== er) begin
                        nMismatched++;
                        $display("[TB] FAIL busy_start_result: got q=%h r=%h expected q=%h r=%h",
                                 quotient, remainder, eq, er);
                    end
                end
            end
        end
        nCompared++;
        if (firstDone != elat) begin
            nMismatched++;
            $display("[TB] FAIL busy_start_latency: got %0d expected %0d", firstDone, elat);
        end
        nCompared++;
        if (nDone != 1) begin
            nMismatched++;
            $display("[TB] FAIL busy_start_done_count: got %0d expected 1", nDone);
        end
    endtask

    // Reset dropped in the middle of CALC
    task automatic test_reset_mid_calc();
        int nDone;
        @(negedge clk);
        fbusA = 32'd100; fbusB = 32'd7; div_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        nCompared++;
        if ({busy, done, div_zero} !== 3'b000 || {quotient, remainder} !== 64'd0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset_outputs: got busy=%0b done=%0b dz=%0b q=%h r=%h expected all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        nDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) nDone++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) nDone++;
        end
        nCompared++;
        if (nDone != 0) begin
            nMismatched++;
            $display("[TB] FAIL mid_reset_no_done: got %0d active cycles expected 0", nDone);
        end
        runAndCheck("post_reset_1div1", 32'd1, 32'd1, 1'b0);
    endtask

    // Randomized operands, issued back to back
    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic s;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                3:       b = a >> $urandom_range(0, 31);
                4:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            runAndCheck("random", a, b, s);
        end
    endtask

    // Test sequence
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        start       = 1'b0;
        div_signed  = 1'b0;
        fbusA       = '0;
        fbusB       = '0;
        reset_n     = 1'b0;
        test_reset();
        test_directed();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
